// File: rtl/coin_pkg.sv
// Shared constants and types for the coin manager: coin geometry, the fixed
// coin positions and the per-slot state encoding.
package coin_pkg;

  localparam int COIN_SIZE = 16;
  localparam int MAX_COINS = 4;

  localparam logic [9:0] COIN_X [MAX_COINS] = '{10'd100, 10'd220, 10'd340, 10'd460};
  localparam logic [9:0] COIN_Y [MAX_COINS] = '{10'd300, 10'd200, 10'd300, 10'd200};

  typedef enum logic {
    ACTIVE = 1'b0,
    HIDDEN = 1'b1
  } slot_state_t;

endpackage

// File: rtl/coin_slot.sv
// One coin slot: ACTIVE/HIDDEN state machine, respawn timer and the
// player-versus-coin hit test.
module coin_slot
  import coin_pkg::*;
#(
  parameter logic [9:0] CX             = 10'd0,
  parameter logic [9:0] CY             = 10'd0,
  parameter int         RESPAWN_FRAMES = 120
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [9:0] PlayerS,
  output logic       active,
  output logic       active_next,
  output logic       hit_now
);

  localparam int             TIMER_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(RESPAWN_FRAMES - 1);
  localparam logic [10:0]    EDGE_OFS = 11'(COIN_SIZE - 1);

  slot_state_t        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               hit;

  // All sums are carried at 11 bits so the overlap test never wraps.
  assign hit = ({1'b0, PlayerX} + {1'b0, PlayerS} >= {1'b0, CX})
            && ({1'b0, CX} + EDGE_OFS + {1'b0, PlayerS} >= {1'b0, PlayerX})
            && ({1'b0, PlayerY} + {1'b0, PlayerS} >= {1'b0, CY})
            && ({1'b0, CY} + EDGE_OFS + {1'b0, PlayerS} >= {1'b0, PlayerY});

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hit_now = 1'b0;
    unique case (state_q)
      ACTIVE: begin
        if (hit) begin
          state_d = HIDDEN;
          timer_d = RELOAD;
          hit_now = 1'b1;
        end
      end
      HIDDEN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (hit) begin
          // Respawning under the player: collected again on the same edge.
          timer_d = RELOAD;
          hit_now = 1'b1;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= ACTIVE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign active      = (state_q == ACTIVE);
  assign active_next = (state_d == ACTIVE);

endmodule

// File: rtl/coin_manager.sv
// Coin manager top: per-slot instances, saturating score adder, collect pulse,
// all-clear flag and the combinational render priority mux.
module coin_manager
  import coin_pkg::*;
#(
  parameter int NUM_COINS      = 4,
  parameter int RESPAWN_FRAMES = 120,
  parameter int SCORE_W        = 8
) (
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [1:0]         COINSIGNAL,
  input  logic [9:0]         PlayerX,
  input  logic [9:0]         PlayerY,
  input  logic [9:0]         PlayerS,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic               coin_on,
  output logic [9:0]         coin_addr,
  output logic               collect_pulse,
  output logic [SCORE_W-1:0] score,
  output logic               all_clear
);

  localparam int CNT_W = $clog2(NUM_COINS + 1);
  localparam int SUM_W = SCORE_W + CNT_W;
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

  logic [NUM_COINS-1:0] slot_active, slot_active_next, slot_hit;

  for (genvar i = 0; i < NUM_COINS; i++) begin : g_slot
    coin_slot #(
      .CX             (COIN_X[i]),
      .CY             (COIN_Y[i]),
      .RESPAWN_FRAMES (RESPAWN_FRAMES)
    ) u_slot (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .PlayerX     (PlayerX),
      .PlayerY     (PlayerY),
      .PlayerS     (PlayerS),
      .active      (slot_active[i]),
      .active_next (slot_active_next[i]),
      .hit_now     (slot_hit[i])
    );
  end

  logic [CNT_W-1:0]   hit_cnt;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               pulse_q, clear_q;

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      hit_cnt = hit_cnt + CNT_W'(slot_hit[i]);
    end
    score_sum = SUM_W'(score_q) + SUM_W'(hit_cnt);
    score_d   = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      score_q <= '0;
      pulse_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      score_q <= score_d;
      pulse_q <= |slot_hit;
      clear_q <= ~|slot_active_next;
    end
  end

  assign score         = score_q;
  assign collect_pulse = pulse_q;
  assign all_clear     = clear_q;

  logic       in_x, in_y;
  logic [3:0] dx, dy;

  // Scan from the highest slot down so the lowest-index hit is written last.
  always_comb begin
    coin_on   = 1'b0;
    coin_addr = '0;
    in_x      = 1'b0;
    in_y      = 1'b0;
    dx        = '0;
    dy        = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      in_x = ({1'b0, DrawX} >= {1'b0, COIN_X[i]})
          && ({1'b0, DrawX} <  {1'b0, COIN_X[i]} + 11'(COIN_SIZE));
      in_y = ({1'b0, DrawY} >= {1'b0, COIN_Y[i]})
          && ({1'b0, DrawY} <  {1'b0, COIN_Y[i]} + 11'(COIN_SIZE));
      if (slot_active[i] && in_x && in_y) begin
        dx        = DrawX[3:0] - COIN_X[i][3:0];
        dy        = DrawY[3:0] - COIN_Y[i][3:0];
        coin_on   = 1'b1;
        coin_addr = {COINSIGNAL, dy, dx};
      end
    end
  end

endmodule

// File: tb/tb_coin_manager.sv
// Directed self-checking bench for coin_manager: reset, collect/respawn,
// render addressing, simultaneous hits, score saturation and reset priority.
module tb_coin_manager;

  logic       Reset;
  logic       frame_clk;
  logic [1:0] COINSIGNAL;
  logic [9:0] PlayerX, PlayerY, PlayerS;
  logic [9:0] DrawX, DrawY;
  logic       coin_on;
  logic [9:0] coin_addr;
  logic       collect_pulse;
  logic [7:0] score;
  logic       all_clear;

  int tests_run    = 0;
  int tests_failed = 0;

  coin_manager #(
    .NUM_COINS      (4),
    .RESPAWN_FRAMES (120),
    .SCORE_W        (8)
  ) dut (
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .COINSIGNAL    (COINSIGNAL),
    .PlayerX       (PlayerX),
    .PlayerY       (PlayerY),
    .PlayerS       (PlayerS),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .coin_on       (coin_on),
    .coin_addr     (coin_addr),
    .collect_pulse (collect_pulse),
    .score         (score),
    .all_clear     (all_clear)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic place_player(input int x, input int y, input int s);
    PlayerX = 10'(x);
    PlayerY = 10'(y);
    PlayerS = 10'(s);
  endtask

  task automatic do_reset();
    place_player(0, 0, 0);
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    int xs [4] = '{100, 220, 340, 460};
    int ys [4] = '{300, 200, 300, 200};
    do_reset();
    tests_run++;
    if (score !== 8'd0) begin
      tests_failed++; $display("FAIL reset_score got %0d want 0", score);
    end
    tests_run++;
    if (collect_pulse !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pulse got %b want 0", collect_pulse);
    end
    tests_run++;
    if (all_clear !== 1'b0) begin
      tests_failed++; $display("FAIL reset_all_clear got %b want 0", all_clear);
    end
    COINSIGNAL = 2'd0;
    for (int i = 0; i < 4; i++) begin
      DrawX = 10'(xs[i]);
      DrawY = 10'(ys[i]);
      #1;
      tests_run++;
      if (coin_on !== 1'b1 || coin_addr !== 10'h000) begin
        tests_failed++;
        $display("FAIL reset_slot%0d_active got on=%b addr=%h want on=1 addr=000", i, coin_on, coin_addr);
      end
    end
  endtask

  task automatic test_single_collect();
    place_player(108, 308, 4);
    tick(1);
    DrawX = 10'd105; DrawY = 10'd303; COINSIGNAL = 2'd2;
    #1;
    tests_run++;
    if (score !== 8'd1 || collect_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_collect got score=%0d pulse=%b want score=1 pulse=1", score, collect_pulse);
    end
    tests_run++;
    if (coin_on !== 1'b0 || coin_addr !== 10'h000) begin
      tests_failed++;
      $display("FAIL render_hidden got on=%b addr=%h want on=0 addr=000", coin_on, coin_addr);
    end
    tests_run++;
    if (all_clear !== 1'b0) begin
      tests_failed++; $display("FAIL single_all_clear got %b want 0", all_clear);
    end
    place_player(0, 0, 0);
    tick(1);
    tests_run++;
    if (collect_pulse !== 1'b0 || score !== 8'd1) begin
      tests_failed++;
      $display("FAIL pulse_drop got pulse=%b score=%0d want pulse=0 score=1", collect_pulse, score);
    end
    tick(118);
    tests_run++;
    if (coin_on !== 1'b0) begin
      tests_failed++; $display("FAIL respawn_early got on=%b want 0 at edge +119", coin_on);
    end
    tick(1);
    tests_run++;
    if (coin_on !== 1'b1 || coin_addr !== 10'h235) begin
      tests_failed++;
      $display("FAIL respawn_render got on=%b addr=%h want on=1 addr=235", coin_on, coin_addr);
    end
  endtask

  task automatic test_render();
    DrawX = 10'd115; DrawY = 10'd315; COINSIGNAL = 2'd2;
    #1;
    tests_run++;
    if (coin_on !== 1'b1 || coin_addr !== 10'h2FF) begin
      tests_failed++;
      $display("FAIL render_corner got on=%b addr=%h want on=1 addr=2ff", coin_on, coin_addr);
    end
    DrawX = 10'd116;
    #1;
    tests_run++;
    if (coin_on !== 1'b0 || coin_addr !== 10'h000) begin
      tests_failed++;
      $display("FAIL render_outside got on=%b addr=%h want on=0 addr=000", coin_on, coin_addr);
    end
    DrawX = 10'd221; DrawY = 10'd202; COINSIGNAL = 2'd3;
    #1;
    tests_run++;
    if (coin_on !== 1'b1 || coin_addr !== 10'h321) begin
      tests_failed++;
      $display("FAIL render_slot1 got on=%b addr=%h want on=1 addr=321", coin_on, coin_addr);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    place_player(280, 250, 200);
    tick(1);
    tests_run++;
    if (score !== 8'd4 || all_clear !== 1'b1 || collect_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_hit got score=%0d clear=%b pulse=%b want 4 1 1", score, all_clear, collect_pulse);
    end
    tick(119);
    tests_run++;
    if (score !== 8'd4 || all_clear !== 1'b1 || collect_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_hold got score=%0d clear=%b pulse=%b want 4 1 0", score, all_clear, collect_pulse);
    end
    tick(1);
    tests_run++;
    if (score !== 8'd8 || collect_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_respawn got score=%0d pulse=%b want 8 1", score, collect_pulse);
    end
  endtask

  task automatic test_saturation();
    tick(61 * 120);
    tests_run++;
    if (score !== 8'd252) begin
      tests_failed++; $display("FAIL sat_before got %0d want 252", score);
    end
    tick(120);
    tests_run++;
    if (score !== 8'd255) begin
      tests_failed++; $display("FAIL sat_reach got %0d want 255", score);
    end
    tick(120);
    tests_run++;
    if (score !== 8'd255 || collect_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_hold got score=%0d pulse=%b want 255 1", score, collect_pulse);
    end
  endtask

  task automatic test_reset_vs_hit();
    do_reset();
    place_player(228, 208, 4);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    place_player(0, 0, 0);
    DrawX = 10'd221; DrawY = 10'd202; COINSIGNAL = 2'd1;
    #1;
    tests_run++;
    if (score !== 8'd0 || collect_pulse !== 1'b0 || coin_on !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_vs_hit got score=%0d pulse=%b on=%b want 0 0 1", score, collect_pulse, coin_on);
    end
    tick(1);
    tests_run++;
    if (score !== 8'd0 || coin_on !== 1'b1 || coin_addr !== 10'h121) begin
      tests_failed++;
      $display("FAIL reset_vs_hit_after got score=%0d on=%b addr=%h want 0 1 121", score, coin_on, coin_addr);
    end
  endtask

  initial begin
    Reset      = 1'b1;
    COINSIGNAL = 2'd0;
    DrawX      = 10'd0;
    DrawY      = 10'd0;
    place_player(0, 0, 0);
    test_reset();
    test_single_collect();
    test_render();
    test_simultaneous();
    test_saturation();
    test_reset_vs_hit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
